// File: rtl/ex_div_pkg.sv
// Shared widths, control encodings and helpers for the execute-stage divider.
// The DIV_EARLY_EXIT_EN build option is consumed by ex_div.sv.
package ex_div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic RstEnable         = 1'b1;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    // Magnitude of an operand; only signed operations treat bit 31 as a sign.
    function automatic logic [RegBus-1:0] div_mag(input logic [RegBus-1:0] v, input logic sgn);
        return (sgn && v[RegBus-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_div_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
interface ex_div_if;
    import ex_div_pkg::*;

    logic                    signed_div_i;
    logic [RegBus-1:0]       opdata1_i;
    logic [RegBus-1:0]       opdata2_i;
    logic                    start_i;
    logic                    annul_i;
    logic [DoubleRegBus-1:0] result_o;
    logic                    ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring 32-bit DIV/DIVU, one quotient bit per cycle, signed fix-up at the end.
// Optional DIV_EARLY_EXIT_EN: finish in one edge when |divisor| > |dividend|.
module ex_div
    import ex_div_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    ex_div_if.slave  div
);

    div_state_t              r_state;
    logic [5:0]              r_cnt;
    logic [DoubleRegBus:0]   r_rem;
    logic [RegBus-1:0]       r_divisor;
    logic                    r_op1_neg;
    logic                    r_op2_neg;
    logic [DoubleRegBus-1:0] r_result;
    logic                    r_ready;

    logic [RegBus-1:0]       w_mag1;
    logic [RegBus-1:0]       w_mag2;
    logic [RegBus:0]         w_trial;
    logic                    w_ge;
    logic [DoubleRegBus:0]   w_next_rem;
    logic [RegBus-1:0]       w_quot;
    logic [RegBus-1:0]       w_remd;
    logic [RegBus-1:0]       w_quot_fix;
    logic [RegBus-1:0]       w_rem_fix;

    assign w_mag1 = div_mag(div.opdata1_i, div.signed_div_i);
    assign w_mag2 = div_mag(div.opdata2_i, div.signed_div_i);

    // Partial remainder stays below 2*divisor, so the 33-bit difference's MSB is a true borrow.
    assign w_trial    = r_rem[DoubleRegBus:RegBus] - {1'b0, r_divisor};
    assign w_ge       = ~w_trial[RegBus];
    assign w_next_rem = w_ge ? {w_trial[RegBus-1:0], r_rem[RegBus-1:0], 1'b1}
                             : {r_rem[DoubleRegBus-1:0], 1'b0};

    assign w_quot     = r_rem[RegBus-1:0];
    assign w_remd     = r_rem[DoubleRegBus:RegBus+1];
    assign w_quot_fix = (r_op1_neg ^ r_op2_neg) ? (~w_quot + 1'b1) : w_quot;
    assign w_rem_fix  = r_op1_neg ? (~w_remd + 1'b1) : w_remd;

    always_ff @(posedge clk) begin
        if (rst_n == RstEnable) begin
            r_state   <= DivFree;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_op1_neg <= 1'b0;
            r_op2_neg <= 1'b0;
            r_result  <= '0;
            r_ready   <= DivResultNotReady;
        end else begin
            case (r_state)
                DivFree: begin
                    if (div.start_i == DivStart && !div.annul_i) begin
                        if (div.opdata2_i == '0) begin
                            r_state <= DivByZero;
`ifdef DIV_EARLY_EXIT_EN
                        end else if (w_mag2 > w_mag1) begin
                            r_state  <= DivEnd;
                            r_result <= {div.opdata1_i, {RegBus{1'b0}}};
                            r_ready  <= DivResultReady;
`endif
                        end else begin
                            r_state   <= DivOn;
                            r_cnt     <= '0;
                            r_rem     <= {{RegBus{1'b0}}, w_mag1, 1'b0};
                            r_divisor <= w_mag2;
                            r_op1_neg <= div.signed_div_i & div.opdata1_i[RegBus-1];
                            r_op2_neg <= div.signed_div_i & div.opdata2_i[RegBus-1];
                        end
                    end else begin
                        r_ready  <= DivResultNotReady;
                        r_result <= '0;
                    end
                end
                DivByZero: begin
                    r_result <= '0;
                    r_state  <= div.annul_i ? DivFree : DivEnd;
                end
                DivOn: begin
                    if (div.annul_i) begin
                        r_state  <= DivFree;
                        r_cnt    <= '0;
                        r_ready  <= DivResultNotReady;
                        r_result <= '0;
                    end else if (r_cnt != 6'd32) begin
                        r_rem <= w_next_rem;
                        r_cnt <= r_cnt + 6'd1;
                    end else begin
                        r_result <= {w_rem_fix, w_quot_fix};
                        r_ready  <= DivResultReady;
                        r_cnt    <= '0;
                        r_state  <= DivEnd;
                    end
                end
                DivEnd: begin
                    if (div.start_i == DivStop || div.annul_i) begin
                        r_state  <= DivFree;
                        r_ready  <= DivResultNotReady;
                        r_result <= '0;
                    end else begin
                        r_ready <= DivResultReady;
                    end
                end
                default: r_state <= DivFree;
            endcase
        end
    end

    assign div.result_o = r_result;
    assign div.ready_o  = r_ready;

endmodule
